// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO word serializer.
package fifo_ser_pkg;

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} ser_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-time down-counter: bit_done marks the last cycle of every bit-time.
module bit_timer
  import fifo_ser_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic bit_done
);

  localparam int TW = cnt_width(CLK_DIV);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("bit_timer: CLK_DIV must be >= 1");
  end

  logic [TW-1:0] cnt;

  assign bit_done = run && (cnt == '0);

  // Reloads on restart and on every terminal count, so each bit gets a full CLK_DIV.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || bit_done) begin
      cnt <= TW'(CLK_DIV - 1);
    end else if (run) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_word_serializer.sv
// Drains a FIFO one word at a time into a start/data/stop framed serial stream.
// state | meaning
// IDLE  | line high, waiting for enable and a non-empty FIFO
// POP   | fifo_rd_en strobe
// LOAD  | capture fifo_rdata into the shift register, restart bit timer
// START | start bit for one bit-time
// DATA  | WIDTH data bits, one bit-time each
// STOP  | stop bit; last cycle counts the word and decides POP or IDLE
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 16
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd_en,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BW = cnt_width(WIDTH);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             bit_done, go, last_bit, cur_bit, in_frame;

  assign go       = enable && !fifo_empty;
  assign last_bit = (bit_cnt == BW'(WIDTH - 1));
  assign cur_bit  = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign in_frame = (state == START) || (state == DATA) || (state == STOP);

  bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .restart  (state == LOAD),
    .run      (in_frame),
    .bit_done (bit_done)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    busy       = 1'b1;
    ser_frame  = 1'b0;
    ser_out    = LINE_IDLE;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) state_nxt = POP;
      end
      POP: begin
        fifo_rd_en = 1'b1;
        state_nxt  = LOAD;
      end
      LOAD: state_nxt = START;
      START: begin
        ser_frame = 1'b1;
        ser_out   = START_BIT;
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        ser_frame = 1'b1;
        ser_out   = cur_bit;
        if (bit_done && last_bit) state_nxt = STOP;
      end
      STOP: begin
        ser_frame = 1'b1;
        ser_out   = STOP_BIT;
        if (bit_done) state_nxt = go ? POP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      words_sent <= '0;
    end else begin
      case (state)
        LOAD:  shreg   <= fifo_rdata;
        START: bit_cnt <= '0;
        DATA: begin
          if (bit_done) begin
            shreg   <= (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) words_sent <= words_sent + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: three serializer configurations driven from one FIFO model.
module tb_fifo_word_serializer;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  int         sel = 0;

  logic rd_a, ser_a, frm_a, busy_a;
  logic rd_b, ser_b, frm_b, busy_b;
  logic rd_c, ser_c, frm_c, busy_c;
  logic [15:0] ws_a, ws_b;
  logic [3:0]  ws_c;
  logic en_a, en_b, en_c;

  logic        obs_rd, obs_ser, obs_frame, obs_busy;
  logic [15:0] obs_ws;

  logic [7:0] q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frm_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  assign en_a = enable && (sel == 0);
  assign en_b = enable && (sel == 1);
  assign en_c = enable && (sel == 2);

  fifo_word_serializer #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(0), .CNT_W(16)) u_lsb (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(en_a), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rd_en(rd_a), .ser_out(ser_a), .ser_frame(frm_a),
    .busy(busy_a), .words_sent(ws_a));

  fifo_word_serializer #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1), .CNT_W(16)) u_msb (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(en_b), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rd_en(rd_b), .ser_out(ser_b), .ser_frame(frm_b),
    .busy(busy_b), .words_sent(ws_b));

  fifo_word_serializer #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(0), .CNT_W(4)) u_fast (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(en_c), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rd_en(rd_c), .ser_out(ser_c), .ser_frame(frm_c),
    .busy(busy_c), .words_sent(ws_c));

  always_comb begin
    obs_rd = rd_a; obs_ser = ser_a; obs_frame = frm_a; obs_busy = busy_a; obs_ws = ws_a;
    case (sel)
      1: begin
        obs_rd = rd_b; obs_ser = ser_b; obs_frame = frm_b; obs_busy = busy_b; obs_ws = ws_b;
      end
      2: begin
        obs_rd = rd_c; obs_ser = ser_c; obs_frame = frm_c; obs_busy = busy_c;
        obs_ws = {12'h000, ws_c};
      end
      default: ;
    endcase
  end

  // FIFO model: read data appears the cycle after the pop strobe.
  always @(posedge sys_clk) begin
    if (obs_rd && q.size() > 0) begin
      fifo_rdata <= q.pop_front();
      fifo_empty <= (q.size() == 0);
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    q.delete();
    fifo_empty = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic sample(input logic s, input logic r, input logic f, input logic b, input int drop_at);
    chk_val($sformatf("ser@%0d", cyc), 32'(obs_ser), 32'(s));
    chk_val($sformatf("rd_en@%0d", cyc), 32'(obs_rd), 32'(r));
    chk_val($sformatf("frame@%0d", cyc), 32'(obs_frame), 32'(f));
    chk_val($sformatf("busy@%0d", cyc), 32'(obs_busy), 32'(b));
    if (obs_frame) frm_cnt++;
    if (cyc == drop_at) enable = 1'b0;
    cyc++;
    tick();
  endtask

  // Called #1 after the edge that sampled enable with a non-empty FIFO.
  // Each bits argument lists the data bits in transmit order, first bit at [7].
  task automatic expect_frames(input int n, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int div, input int drop_at);
    logic [7:0] bits;
    cyc = 0;
    frm_cnt = 0;
    for (int k = 0; k < n; k++) begin
      bits = (k == 0) ? b0 : (k == 1) ? b1 : b2;
      sample(1'b1, 1'b1, 1'b0, 1'b1, drop_at);
      sample(1'b1, 1'b0, 1'b0, 1'b1, drop_at);
      for (int d = 0; d < div; d++) sample(1'b0, 1'b0, 1'b1, 1'b1, drop_at);
      for (int j = 0; j < 8; j++)
        for (int d = 0; d < div; d++) sample(bits[7-j], 1'b0, 1'b1, 1'b1, drop_at);
      for (int d = 0; d < div; d++) sample(1'b1, 1'b0, 1'b1, 1'b1, drop_at);
    end
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b0, 1'b0, 1'b0, drop_at);
    chk_val("frame_len", 32'(frm_cnt), 32'(n * 10 * div));
  endtask

  task automatic wait_idle(input int max_cyc);
    int waited;
    waited = 0;
    tick();
    while ((obs_busy || !fifo_empty) && waited < max_cyc) begin
      tick();
      waited++;
    end
    chk_val("idle_timeout", 32'(waited >= max_cyc), 32'h0);
  endtask

  initial begin
    int rd_seen, busy_seen;

    sel = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk_val("rst_ser", 32'(ser_a), 32'h1);
    chk_val("rst_rd_en", 32'(rd_a), 32'h0);
    chk_val("rst_busy", 32'(busy_a), 32'h0);
    chk_val("rst_frame", 32'(frm_a), 32'h0);
    chk_val("rst_ws", 32'(ws_a), 32'h0);
    chk_val("rst_ws_fast", 32'(ws_c), 32'h0);
    rst_n = 1'b1;

    // Single word A5, LSB first
    sel = 0;
    tick();
    enable = 1'b1;
    push(8'hA5);
    tick();
    expect_frames(1, 8'b1010_0101, 8'h00, 8'h00, 4, -1);
    chk_val("single_ws", 32'(obs_ws), 32'd1);

    // Back-to-back, LSB first
    do_reset();
    enable = 1'b1;
    push(8'h01); push(8'h80); push(8'hFF);
    tick();
    expect_frames(3, 8'b1000_0000, 8'b0000_0001, 8'b1111_1111, 4, -1);
    chk_val("b2b_ws", 32'(obs_ws), 32'd3);

    // Back-to-back, MSB first
    sel = 1;
    do_reset();
    enable = 1'b1;
    push(8'h01); push(8'h80); push(8'hFF);
    tick();
    expect_frames(3, 8'b0000_0001, 8'b1000_0000, 8'b1111_1111, 4, -1);
    chk_val("msb_ws", 32'(obs_ws), 32'd3);

    // Flow control: enable drops mid-DATA of word 1
    sel = 0;
    do_reset();
    enable = 1'b1;
    push(8'h3C); push(8'hC3);
    tick();
    expect_frames(1, 8'b0011_1100, 8'h00, 8'h00, 4, 20);
    chk_val("flow_ws1", 32'(obs_ws), 32'd1);
    chk_val("flow_still_queued", 32'(fifo_empty), 32'h0);
    enable = 1'b1;
    tick();
    expect_frames(1, 8'b1100_0011, 8'h00, 8'h00, 4, -1);
    chk_val("flow_ws2", 32'(obs_ws), 32'd2);

    // Reset inside the third data bit
    do_reset();
    enable = 1'b1;
    push(8'h00);
    tick();
    repeat (15) tick();
    chk_val("pre_rst_ser", 32'(obs_ser), 32'h0);
    chk_val("pre_rst_frame", 32'(obs_frame), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk_val("async_rst_ser", 32'(obs_ser), 32'h1);
    chk_val("async_rst_frame", 32'(obs_frame), 32'h0);
    chk_val("async_rst_busy", 32'(obs_busy), 32'h0);
    #2 rst_n = 1'b1;
    rd_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_rd) rd_seen++;
      if (obs_busy) busy_seen++;
    end
    chk_val("post_rst_rd", 32'(rd_seen), 32'h0);
    chk_val("post_rst_busy", 32'(busy_seen), 32'h0);
    chk_val("post_rst_ws", 32'(obs_ws), 32'h0);

    // FIFO empty throughout
    do_reset();
    enable = 1'b1;
    rd_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_rd) rd_seen++;
    end
    chk_val("empty_no_pop", 32'(rd_seen), 32'h0);
    chk_val("empty_idle", 32'(obs_busy), 32'h0);

    // CLK_DIV=1 and words_sent wrap at CNT_W=4
    sel = 2;
    do_reset();
    enable = 1'b1;
    push(8'hA5);
    tick();
    expect_frames(1, 8'b1010_0101, 8'h00, 8'h00, 1, -1);
    chk_val("fast_ws1", 32'(obs_ws), 32'd1);
    for (int i = 0; i < 14; i++) push(8'h55);
    wait_idle(500);
    chk_val("fast_ws15", 32'(obs_ws), 32'd15);
    push(8'h55);
    wait_idle(100);
    chk_val("fast_ws_wrap", 32'(obs_ws), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Sits directly downstream of the team's 16x32 FIFO and drains it: pops one word at a time and shifts it out as a framed bit-serial stream.
- Frame: start bit (0), WIDTH data bits, stop bit (1); each bit is held for CLK_DIV clocks.
- Serial line idles high. Provides busy/frame status and a sent-word counter for debug.

Parameters:
- WIDTH, 32, data word width; equals the FIFO width.
- CLK_DIV, 4, clocks per serial bit; legal range >= 1; elaboration error if < 1.
- MSB_FIRST, 0, data bit order: 0 = LSB first, 1 = MSB first.
- CNT_W, 16, width of the words_sent counter.

Ports:
- sys_clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  permits starting new frames; sampled only in IDLE and on the last STOP cycle.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdata  input  WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  pop strobe, one cycle per word.
- ser_out  output  1  serial line; idles 1.
- ser_frame  output  1  high from the first START cycle through the last STOP cycle.
- busy  output  1  high in every state except IDLE.
- words_sent  output  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Interface: one clock, sys_clk. Reset rst_n is asynchronous, active-low. All outputs are registered or Moore-decoded from registered state.
- Reset values: state=IDLE, fifo_rd_en=0, ser_out=1, ser_frame=0, busy=0, words_sent=0, shift register=0, bit and tick counters=0.
- FSM states: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE -> POP: when enable=1 and fifo_empty=0 are sampled at a clock edge.
- POP (1 cycle): fifo_rd_en=1. fifo_rd_en is high in no other state.
- LOAD (1 cycle): captures fifo_rdata into the shift register; ser_out stays 1.
- START: ser_out=0 for CLK_DIV cycles.
- DATA: WIDTH bit-times of CLK_DIV cycles each; ser_out = current bit, shifted per MSB_FIRST.
- STOP: ser_out=1 for CLK_DIV cycles.
- Last STOP cycle: words_sent increments. Next state is POP if enable=1 and fifo_empty=0, otherwise IDLE.
- Latency: if the condition is sampled at edge t, POP occupies cycle t+1, LOAD t+2, and ser_out falls at t+3.
- Frame length: exactly (WIDTH+2)*CLK_DIV cycles with ser_frame=1.
- Back-to-back frames: exactly 2 idle-high cycles (POP, LOAD) between frames.
- Tick counter: counts 0..CLK_DIV-1 within each bit-time and restarts at 0 for every bit, including START.
- Bit counter: counts 0..WIDTH-1 in DATA.
- enable deasserted mid-frame: the current frame completes unchanged; no further pop.
- fifo_empty asserted during a frame: has no effect until the STOP decision point.
- fifo_rd_en is never asserted while fifo_empty=1 is sampled at the decision edge.
- Reset mid-frame: ser_out returns to 1 and ser_frame to 0 immediately, asynchronously. The in-flight word is discarded; it was already popped and is not re-read.
- words_sent wrap: 2^CNT_W-1 -> 0, no saturation.
- CLK_DIV=1: a frame lasts WIDTH+2 cycles, and all rules above still hold.

Decomposition:
- Package fifo_ser_pkg:
  - typedef enum logic [2:0] ser_state_t {IDLE, POP, LOAD, START, DATA, STOP}.
  - Localparam helper for counter widths: $clog2 of CLK_DIV and of WIDTH, minimum 1.
  - Constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module bit_timer:
  - Parameterised CLK_DIV down-counter with a restart input.
  - Emits a one-cycle bit_done pulse on the last cycle of each bit-time.
  - Instantiated once; the FSM advances on bit_done.

Test Plan:
- Reset: hold rst_n=0 -> ser_out=1, fifo_rd_en=0, busy=0, words_sent=0.
- Single word, WIDTH=8, CLK_DIV=4, MSB_FIRST=0, fifo_rdata=8'hA5, enable=1, fifo_empty falls at edge t:
  - fifo_rd_en pulses at t+1 only.
  - ser_out=0 during t+3..t+6.
  - Data bits 1,0,1,0,0,1,0,1, each held 4 cycles.
  - Stop bit 1 for 4 cycles; ser_frame high for 40 cycles; words_sent=1.
- Back-to-back, 3 words 8'h01, 8'h80, 8'hFF with fifo_empty held low:
  - Exactly 2 high cycles between frames and 3 rd_en pulses; words_sent=3.
  - Rerun with MSB_FIRST=1: 8'h01 emits bits 0000_0001.
- Flow control:
  - enable dropped during DATA of word 1 with word 2 present -> word 1 completes; no pop; state returns to IDLE.
  - Re-raise enable -> pop occurs on the next cycle.
- Reset mid-frame: assert rst_n=0 in the 3rd data bit -> ser_out=1 asynchronously, before the next clock edge; after release, with the FIFO empty, no activity and words_sent=0.
- Boundaries:
  - CLK_DIV=1 -> frame length WIDTH+2 cycles.
  - words_sent preset near max (CNT_W=4, 16 frames) -> wraps to 0.
  - fifo_empty=1 throughout -> fifo_rd_en never asserted.
